avalon_st_packet_source: RTL and testbench

Avalon-ST transmitter that generates framed packets (startofpacket/endofpacket) of incrementing data on command, for driving stream sinks and buffers in the cocotb test designs. It honours ready backpressure with readyLatency 0. It can insert programmable idle gaps between beats and reports per-packet completion.

---
 rtl/avalon_st_pkg.sv | 17 +
 rtl/avalon_st_gap_timer.sv | 28 ++
 rtl/avalon_st_packet_source.sv | 132 +++++++++++++
 tb/tb_avalon_st_packet_source.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/avalon_st_pkg.sv
// Shared types and default widths for the Avalon-ST packet source and any
// matching stream sink/checker.
package avalon_st_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 8;
  localparam int unsigned DEFAULT_LEN_WIDTH   = 8;
  localparam int unsigned DEFAULT_GAP_WIDTH   = 4;
  localparam int unsigned DEFAULT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/avalon_st_gap_timer.sv
// Loadable down-counter timing the idle gap between beats.
// expired is high on the last gap cycle (count of 1, or a zero load).
module avalon_st_gap_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             count,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign expired = (cnt == '0) || (cnt == WIDTH'(1));

endmodule

// File: rtl/avalon_st_packet_source.sv
// Avalon-ST packet source: emits framed packets of incrementing data on
// command, honours readyLatency-0 backpressure, optional inter-beat gaps.
module avalon_st_packet_source
  import avalon_st_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH   = DEFAULT_LEN_WIDTH,
  parameter int unsigned GAP_WIDTH   = DEFAULT_GAP_WIDTH,
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   pkt_len,
  input  logic [DATA_WIDTH-1:0]  first_data,
  input  logic [GAP_WIDTH-1:0]   gap_cycles,
  output logic                   aso_valid,
  output logic [DATA_WIDTH-1:0]  aso_data,
  output logic                   aso_startofpacket,
  output logic                   aso_endofpacket,
  input  logic                   aso_ready,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] pkt_count
);

  state_t state, next_state;

  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  idx_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic fire;
  logic last_beat;
  logic gap_expired;
  logic gap_load;
  logic advance;

  assign fire      = (state == SEND) && aso_ready;
  assign last_beat = (idx_q == (len_q - LEN_WIDTH'(1)));
  assign gap_load  = fire && !last_beat && (gap_q != '0);
  // Beat data/index advance only when the next beat is actually presented,
  // so aso_data keeps the previous beat throughout a gap.
  assign advance   = (fire && !last_beat && (gap_q == '0)) ||
                     ((state == GAP) && gap_expired);

  avalon_st_gap_timer #(
    .WIDTH(GAP_WIDTH)
  ) u_gap_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (gap_load),
    .count     (state == GAP),
    .load_value(gap_q),
    .expired   (gap_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = (pkt_len == '0) ? FINISH : SEND;
        end
      end
      SEND: begin
        if (aso_ready) begin
          if (last_beat) begin
            next_state = FINISH;
          end else if (gap_q != '0) begin
            next_state = GAP;
          end
        end
      end
      GAP: begin
        if (gap_expired) begin
          next_state = SEND;
        end
      end
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    aso_valid         = (state == SEND);
    aso_startofpacket = (state == SEND) && (idx_q == '0);
    aso_endofpacket   = (state == SEND) && last_beat;
    busy              = (state != IDLE);
    done              = (state == FINISH);
  end

  assign aso_data = data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q  <= '0;
      idx_q  <= '0;
      gap_q  <= '0;
      data_q <= '0;
    end else if ((state == IDLE) && start) begin
      len_q <= pkt_len;
      gap_q <= gap_cycles;
      idx_q <= '0;
      // A zero-length packet presents nothing, so the last data stays put.
      if (pkt_len != '0) begin
        data_q <= first_data;
      end
    end else if (advance) begin
      idx_q  <= idx_q + LEN_WIDTH'(1);
      data_q <= data_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count <= '0;
    end else if (state == FINISH) begin
      pkt_count <= pkt_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_avalon_st_packet_source.sv
// Directed bench for avalon_st_packet_source: cycle table plus a
// reset-during-stall sequence.
module tb_avalon_st_packet_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pkt_len;
  logic [7:0]  first_data;
  logic [3:0]  gap_cycles;
  logic        aso_valid;
  logic [7:0]  aso_data;
  logic        aso_startofpacket;
  logic        aso_endofpacket;
  logic        aso_ready;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;

  avalon_st_packet_source #(
    .DATA_WIDTH (8),
    .LEN_WIDTH  (8),
    .GAP_WIDTH  (4),
    .COUNT_WIDTH(16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .pkt_len          (pkt_len),
    .first_data       (first_data),
    .gap_cycles       (gap_cycles),
    .aso_valid        (aso_valid),
    .aso_data         (aso_data),
    .aso_startofpacket(aso_startofpacket),
    .aso_endofpacket  (aso_endofpacket),
    .aso_ready        (aso_ready),
    .busy             (busy),
    .done             (done),
    .pkt_count        (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [7:0]  len;
    logic [7:0]  first;
    logic [3:0]  gap;
    logic        rdy;
    logic        v;
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    logic        bsy;
    logic        dn;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Non-start rows carry junk command fields; they must be ignored.
  function automatic vec_t cyc(input logic rdy, input logic v, input logic [7:0] d,
                               input logic sop, input logic eop, input logic bsy,
                               input logic dn, input logic [15:0] cnt);
    vec_t r;
    r.st = 1'b0; r.len = 8'hEE; r.first = 8'h77; r.gap = 4'hA;
    r.rdy = rdy; r.v = v; r.d = d; r.sop = sop; r.eop = eop;
    r.bsy = bsy; r.dn = dn; r.cnt = cnt;
    return r;
  endfunction

  function automatic vec_t go(input logic [7:0] len, input logic [7:0] first,
                              input logic [3:0] gap, input logic bsy,
                              input logic [15:0] cnt);
    vec_t r;
    r = cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, bsy, 1'b0, cnt);
    r.st = 1'b1; r.len = len; r.first = first; r.gap = gap;
    return r;
  endfunction

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                            input logic sop, input logic eop, input logic bsy,
                            input logic dn, input logic [15:0] cnt);
    check({tag, ".valid"}, 32'(aso_valid), 32'(v));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".count"}, 32'(pkt_count), 32'(cnt));
    if (v) begin
      check({tag, ".data"}, 32'(aso_data), 32'(d));
      check({tag, ".sop"}, 32'(aso_startofpacket), 32'(sop));
      check({tag, ".eop"}, 32'(aso_endofpacket), 32'(eop));
    end
  endtask

  initial begin
    // len 4, first 0x10, no gap
    vecs.push_back(go(8'd4, 8'h10, 4'd0, 1'b0, 16'd0));
    vecs.push_back(cyc(1, 1, 8'h10, 1, 0, 1, 0, 16'd0));
    vecs.push_back(cyc(1, 1, 8'h11, 0, 0, 1, 0, 16'd0));
    vecs.push_back(cyc(1, 1, 8'h12, 0, 0, 1, 0, 16'd0));
    vecs.push_back(cyc(1, 1, 8'h13, 0, 1, 1, 0, 16'd0));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 1, 1, 16'd0));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 0, 0, 16'd1));
    // len 3, first 0xFE, ready 1,0,0,1,1, data wraps
    vecs.push_back(go(8'd3, 8'hFE, 4'd0, 1'b0, 16'd1));
    vecs.push_back(cyc(1, 1, 8'hFE, 1, 0, 1, 0, 16'd1));
    vecs.push_back(cyc(0, 1, 8'hFF, 0, 0, 1, 0, 16'd1));
    vecs.push_back(cyc(0, 1, 8'hFF, 0, 0, 1, 0, 16'd1));
    vecs.push_back(cyc(1, 1, 8'hFF, 0, 0, 1, 0, 16'd1));
    vecs.push_back(cyc(1, 1, 8'h00, 0, 1, 1, 0, 16'd1));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 1, 1, 16'd1));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 0, 0, 16'd2));
    // len 1: sop and eop on the same beat
    vecs.push_back(go(8'd1, 8'hA5, 4'd0, 1'b0, 16'd2));
    vecs.push_back(cyc(1, 1, 8'hA5, 1, 1, 1, 0, 16'd2));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 1, 1, 16'd2));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 0, 0, 16'd3));
    // len 0: no beats, straight to completion
    vecs.push_back(go(8'd0, 8'h33, 4'd0, 1'b0, 16'd3));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 1, 1, 16'd3));
    // len 3, gap 2: valid 1,0,0,1,0,0,1; start inside the gap is ignored
    vecs.push_back(go(8'd3, 8'h20, 4'd2, 1'b0, 16'd4));
    vecs.push_back(cyc(1, 1, 8'h20, 1, 0, 1, 0, 16'd4));
    vecs.push_back(go(8'd7, 8'h99, 4'd0, 1'b1, 16'd4));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 1, 0, 16'd4));
    vecs.push_back(cyc(1, 1, 8'h21, 0, 0, 1, 0, 16'd4));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 1, 0, 16'd4));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 1, 0, 16'd4));
    vecs.push_back(cyc(1, 1, 8'h22, 0, 1, 1, 0, 16'd4));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 1, 1, 16'd4));
    // start on the first idle cycle after busy falls; len 2, gap 1
    vecs.push_back(go(8'd2, 8'h30, 4'd1, 1'b0, 16'd5));
    vecs.push_back(cyc(1, 1, 8'h30, 1, 0, 1, 0, 16'd5));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 1, 0, 16'd5));
    vecs.push_back(cyc(1, 1, 8'h31, 0, 1, 1, 0, 16'd5));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 1, 1, 16'd5));
    vecs.push_back(cyc(1, 0, 8'h00, 0, 0, 0, 0, 16'd6));

    reset = 1'b0; start = 1'b0; aso_ready = 1'b0;
    pkt_len = '0; first_data = '0; gap_cycles = '0;
    #12;
    expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("reset.data", 32'(aso_data), 32'h0);
    check("reset.sop", 32'(aso_startofpacket), 32'h0);
    check("reset.eop", 32'(aso_endofpacket), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start      = vecs[i].st;
      pkt_len    = vecs[i].len;
      first_data = vecs[i].first;
      gap_cycles = vecs[i].gap;
      aso_ready  = vecs[i].rdy;
      expect_out($sformatf("v%0d", i), vecs[i].v, vecs[i].d, vecs[i].sop,
                 vecs[i].eop, vecs[i].bsy, vecs[i].dn, vecs[i].cnt);
    end

    // Reset asserted while beat 2 of 5 is stalled
    @(negedge clk);
    start = 1'b1; pkt_len = 8'd5; first_data = 8'h40; gap_cycles = 4'd0; aso_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_out("r.b0", 1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 16'd6);
    @(negedge clk);
    expect_out("r.b1", 1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 16'd6);
    @(negedge clk);
    aso_ready = 1'b0;
    expect_out("r.b2", 1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 16'd6);
    @(negedge clk);
    expect_out("r.stall", 1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 16'd6);
    #2 reset = 1'b0;
    #1;
    expect_out("r.async", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("r.async.sop", 32'(aso_startofpacket), 32'h0);
    check("r.async.data", 32'(aso_data), 32'h0);
    @(negedge clk);
    reset = 1'b1; aso_ready = 1'b1;
    @(negedge clk);
    expect_out("r.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    start = 1'b1; pkt_len = 8'd2; first_data = 8'h50; gap_cycles = 4'd0;
    @(negedge clk);
    start = 1'b0;
    expect_out("r.n0", 1'b1, 8'h50, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    @(negedge clk);
    expect_out("r.n1", 1'b1, 8'h51, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    @(negedge clk);
    expect_out("r.done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    @(negedge clk);
    expect_out("r.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
